// File: rtl/reaction_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ninja_pkg                                                 |
// | Purpose  : Shared types and constants for the reaction_timer round   |
// |            controller (FSM state, BCD limits, LFSR taps).            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ninja_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    RESULT  = 3'd3,
    FOUL    = 3'd4
  } state_t;

  localparam logic [11:0] BCD_MAX   = 12'h999;
  localparam int          TICK_HZ   = 10;
  // Fibonacci taps 8,6,5,4 expressed as a bit mask over lfsr[7:0].
  localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

  // Numeric compare of two 3-digit BCD values, most significant digit first.
  function automatic logic bcd_lt(input logic [11:0] a, input logic [11:0] b);
    logic lt;
    logic decided;
    lt      = 1'b0;
    decided = 1'b0;
    for (int d = 2; d >= 0; d--) begin
      if (!decided && (a[4*d +: 4] != b[4*d +: 4])) begin
        lt      = (a[4*d +: 4] < b[4*d +: 4]);
        decided = 1'b1;
      end
    end
    return lt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reaction_timer_if                                         |
// | Purpose  : Game-side signal bundle of the reaction timer: tick       |
// |            input, player buttons, generator enable and results.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface reaction_timer_if;
  logic        clk_100ms;
  logic        start;
  logic        hit;
  logic        cnt_en;
  logic        go_led;
  logic [11:0] bcd_time;
  logic        done;
  logic        foul;
  logic        timeout;
  logic [11:0] best_bcd;

  modport master (
    output clk_100ms, start, hit,
    input  cnt_en, go_led, bcd_time, done, foul, timeout, best_bcd
  );

  modport slave (
    input  clk_100ms, start, hit,
    output cnt_en, go_led, bcd_time, done, foul, timeout, best_bcd
  );
endinterface
`default_nettype wire

// File: rtl/reaction_timer_bcd_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_digit                                                 |
// | Purpose  : One BCD digit counter with synchronous clear and          |
// |            increment; nine flags the digit about to roll over.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bcd_digit (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       clr,
  input  wire logic       inc,
  output logic [3:0]      q,
  output logic            nine
);

  logic [3:0] r_q;

  // Digit register: clear has priority, increment wraps 9 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q    = r_q;
  assign nine = (r_q == 4'd9);

endmodule
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reaction_timer                                            |
// | Purpose  : Reflex-game round controller. Waits a pseudo-random       |
// |            number of 100 ms ticks, lights GO, then counts ticks in   |
// |            BCD (00.0-99.9 s) until the player hits.                  |
// | Options  : BEST_SCORE_EN - keep the best valid time since reset.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reaction_timer
  import ninja_pkg::*;
#(
  parameter int         MIN_WAIT  = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  wire logic        clk,
  input  wire logic        rst,
  reaction_timer_if.slave  bus
);

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_wait_cnt;
  logic        r_clk_100ms_q;
  logic        r_cnt_en;
  logic        r_go_led;
  logic        r_done;
  logic        r_foul;
  logic        r_timeout;

  logic        w_tick;
  logic        w_start_ok;
  logic        w_sat;
  logic        w_count;
  logic [2:0]  w_inc;
  logic [2:0]  w_nine;
  logic [11:0] w_bcd;

  assign w_tick     = bus.clk_100ms & ~r_clk_100ms_q;
  assign w_start_ok = bus.start & ((r_state == IDLE) | (r_state == RESULT) | (r_state == FOUL));
  assign w_sat      = &w_nine;
  // A hit in the same cycle as a tick stops the count before that tick lands.
  assign w_count    = (r_state == MEASURE) & w_tick & ~bus.hit & ~w_sat;

  assign w_inc[0] = w_count;
  assign w_inc[1] = w_count & w_nine[0];
  assign w_inc[2] = w_count & w_nine[0] & w_nine[1];

  // Rising-edge detector on the tick generator's square wave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_clk_100ms_q <= 1'b0;
    else     r_clk_100ms_q <= bus.clk_100ms;
  end

  // Free-running Fibonacci LFSR supplying the random part of the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  for (genvar i = 0; i < 3; i++) begin : g_digit
    bcd_digit u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_start_ok),
      .inc  (w_inc[i]),
      .q    (w_bcd[4*i +: 4]),
      .nine (w_nine[i])
    );
  end

  // Round FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      r_cnt_en   <= 1'b0;
      r_go_led   <= 1'b0;
      r_done     <= 1'b0;
      r_foul     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESULT, FOUL: begin
          if (bus.start) begin
            r_wait_cnt <= 8'(MIN_WAIT) + {4'd0, r_lfsr[3:0]};
            r_done     <= 1'b0;
            r_foul     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt_en   <= 1'b1;
            r_state    <= ARM;
          end
        end
        ARM: begin
          if (bus.hit) begin
            r_foul   <= 1'b1;
            r_cnt_en <= 1'b0;
            r_state  <= FOUL;
          end else if (w_tick) begin
            if (r_wait_cnt == 8'd0) begin
              r_go_led <= 1'b1;
              r_state  <= MEASURE;
            end else begin
              r_wait_cnt <= r_wait_cnt - 8'd1;
            end
          end
        end
        MEASURE: begin
          if (bus.hit) begin
            r_done   <= 1'b1;
            r_go_led <= 1'b0;
            r_cnt_en <= 1'b0;
            r_state  <= RESULT;
          end else if (w_tick && w_sat) begin
            r_timeout <= 1'b1;
            r_go_led  <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_state   <= RESULT;
          end
        end
        default: begin
          r_cnt_en <= 1'b0;
          r_go_led <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

`ifdef BEST_SCORE_EN
  logic [11:0] r_best;

  // Best time tracks only hit-terminated rounds; foul and timeout never reach here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best <= BCD_MAX;
    end else if ((r_state == MEASURE) && bus.hit && bcd_lt(w_bcd, r_best)) begin
      r_best <= w_bcd;
    end
  end

  assign bus.best_bcd = r_best;
`else
  assign bus.best_bcd = BCD_MAX;
`endif

  assign bus.cnt_en   = r_cnt_en;
  assign bus.go_led   = r_go_led;
  assign bus.bcd_time = w_bcd;
  assign bus.done     = r_done;
  assign bus.foul     = r_foul;
  assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reaction_timer                                         |
// | Purpose  : Directed self-checking bench for reaction_timer.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_reaction_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   tick_cnt    = 0;
  int   half_ns     = 1000;
  logic [7:0] m_lfsr;

`ifdef BEST_SCORE_EN
  localparam logic [11:0] EXP_B0 = 12'h045;
  localparam logic [11:0] EXP_B1 = 12'h031;
`else
  localparam logic [11:0] EXP_B0 = 12'h999;
  localparam logic [11:0] EXP_B1 = 12'h999;
`endif

  reaction_timer_if bus();

  reaction_timer #(.MIN_WAIT(10), .LFSR_SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  // Tick generator square wave; edges fall at 5 mod 20 ns, clear of both clock edges.
  initial begin
    bus.clk_100ms = 1'b0;
    #5;
    forever begin
      #(half_ns);
      bus.clk_100ms = ~bus.clk_100ms;
      if (bus.clk_100ms) tick_cnt++;
    end
  end

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic start_and_go(output bit ok, output int edges, output logic [3:0] lf);
    int base;
    @(negedge clk);
    lf = m_lfsr[3:0];
    base = tick_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (bus.go_led === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    edges = tick_cnt - base;
  endtask

  task automatic wait_ticks(input int target, output bit ok);
    for (int i = 0; i < 200000 && tick_cnt < target; i++) @(negedge clk);
    ok = (tick_cnt >= target);
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (bus.cnt_en !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_en: got %b want 0", bus.cnt_en); end
    vectors++; if (bus.go_led !== 1'b0) begin miscompares++; $display("FAIL reset_go_led: got %b want 0", bus.go_led); end
    vectors++; if ({bus.done, bus.foul, bus.timeout} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {bus.done, bus.foul, bus.timeout}); end
    vectors++; if (bus.bcd_time !== 12'h000) begin miscompares++; $display("FAIL reset_bcd: got %h want 000", bus.bcd_time); end
    vectors++; if (bus.best_bcd !== 12'h999) begin miscompares++; $display("FAIL reset_best: got %h want 999", bus.best_bcd); end
    rst = 1'b0;
  endtask

  task automatic test_arm_and_measure();
    bit ok; int edges; logic [3:0] lf; int base;
    start_and_go(ok, edges, lf);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL go_seen: got %b want 1", ok); end
    vectors++; if (edges != 10 + int'(lf) + 1) begin miscompares++; $display("FAIL go_edges: got %0d want %0d", edges, 10 + int'(lf) + 1); end
    vectors++; if (bus.cnt_en !== 1'b1) begin miscompares++; $display("FAIL go_cnt_en: got %b want 1", bus.cnt_en); end
    base = tick_cnt;
    wait_ticks(base + 5, ok);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++; if ({bus.go_led, bus.cnt_en} !== 2'b11) begin miscompares++; $display("FAIL start_ignored: got %b want 11", {bus.go_led, bus.cnt_en}); end
    wait_ticks(base + 23, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wait23: got %b want 1", ok); end
    pulse_hit();
    vectors++; if (bus.bcd_time !== 12'h023) begin miscompares++; $display("FAIL hit_bcd: got %h want 023", bus.bcd_time); end
    vectors++; if ({bus.done, bus.go_led, bus.cnt_en, bus.foul} !== 4'b1000) begin miscompares++; $display("FAIL hit_flags: got %b want 1000", {bus.done, bus.go_led, bus.cnt_en, bus.foul}); end
  endtask

  task automatic test_foul();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    pulse_hit();
    vectors++; if ({bus.foul, bus.go_led, bus.cnt_en, bus.done} !== 4'b1000) begin miscompares++; $display("FAIL foul_flags: got %b want 1000", {bus.foul, bus.go_led, bus.cnt_en, bus.done}); end
    vectors++; if (bus.bcd_time !== 12'h000) begin miscompares++; $display("FAIL foul_bcd: got %h want 000", bus.bcd_time); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++; if ({bus.foul, bus.cnt_en} !== 2'b01) begin miscompares++; $display("FAIL rearm: got %b want 01", {bus.foul, bus.cnt_en}); end
    pulse_hit();
    vectors++; if (bus.foul !== 1'b1) begin miscompares++; $display("FAIL refoul: got %b want 1", bus.foul); end
  endtask

  task automatic test_timeout();
    bit ok; int edges; logic [3:0] lf; int base;
    start_and_go(ok, edges, lf);
    base = tick_cnt;
    wait_ticks(base + 999, ok);
    vectors++; if ({bus.timeout, bus.go_led} !== 2'b01) begin miscompares++; $display("FAIL pre_timeout: got %b want 01", {bus.timeout, bus.go_led}); end
    vectors++; if (bus.bcd_time !== 12'h999) begin miscompares++; $display("FAIL pre_timeout_bcd: got %h want 999", bus.bcd_time); end
    wait_ticks(base + 1000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wait1000: got %b want 1", ok); end
    vectors++; if ({bus.timeout, bus.done, bus.go_led, bus.cnt_en} !== 4'b1000) begin miscompares++; $display("FAIL timeout_flags: got %b want 1000", {bus.timeout, bus.done, bus.go_led, bus.cnt_en}); end
    vectors++; if (bus.bcd_time !== 12'h999) begin miscompares++; $display("FAIL timeout_bcd: got %h want 999", bus.bcd_time); end
  endtask

  task automatic test_hit_with_tick();
    bit ok; int edges; logic [3:0] lf; int base;
    start_and_go(ok, edges, lf);
    base = tick_cnt;
    wait_ticks(base + 9, ok);
    vectors++; if (bus.bcd_time !== 12'h009) begin miscompares++; $display("FAIL at9_bcd: got %h want 009", bus.bcd_time); end
    for (int i = 0; i < 2000 && tick_cnt < base + 10; i++) #2;
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    vectors++; if (bus.bcd_time !== 12'h009) begin miscompares++; $display("FAIL hit_tick_bcd: got %h want 009", bus.bcd_time); end
    vectors++; if ({bus.done, bus.timeout} !== 2'b10) begin miscompares++; $display("FAIL hit_tick_flags: got %b want 10", {bus.done, bus.timeout}); end
  endtask

  task automatic test_best_and_reset();
    bit ok; int edges; logic [3:0] lf; int base;
    int          n   [4] = '{45, 31, 0, 50};
    logic [11:0] eb  [4];
    logic [11:0] ebc [4] = '{12'h045, 12'h031, 12'h000, 12'h050};
    eb[0] = EXP_B0; eb[1] = EXP_B1; eb[2] = EXP_B1; eb[3] = EXP_B1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (r == 2) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        pulse_hit();
        vectors++; if (bus.foul !== 1'b1) begin miscompares++; $display("FAIL best_round_foul: got %b want 1", bus.foul); end
      end else begin
        start_and_go(ok, edges, lf);
        base = tick_cnt;
        wait_ticks(base + n[r], ok);
        pulse_hit();
        vectors++; if (bus.bcd_time !== ebc[r]) begin miscompares++; $display("FAIL best_round%0d_bcd: got %h want %h", r, bus.bcd_time, ebc[r]); end
      end
      vectors++; if (bus.best_bcd !== eb[r]) begin miscompares++; $display("FAIL best_round%0d: got %h want %h", r, bus.best_bcd, eb[r]); end
    end
    start_and_go(ok, edges, lf);
    base = tick_cnt;
    wait_ticks(base + 5, ok);
    #3;
    rst = 1'b1;
    #1;
    vectors++; if ({bus.cnt_en, bus.go_led, bus.done, bus.foul, bus.timeout} !== 5'b00000) begin miscompares++; $display("FAIL async_rst_flags: got %b want 00000", {bus.cnt_en, bus.go_led, bus.done, bus.foul, bus.timeout}); end
    vectors++; if (bus.bcd_time !== 12'h000) begin miscompares++; $display("FAIL async_rst_bcd: got %h want 000", bus.bcd_time); end
    vectors++; if (bus.best_bcd !== 12'h999) begin miscompares++; $display("FAIL async_rst_best: got %h want 999", bus.best_bcd); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ({bus.cnt_en, bus.go_led} !== 2'b00) begin miscompares++; $display("FAIL post_rst_idle: got %b want 00", {bus.cnt_en, bus.go_led}); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    test_reset();
    test_arm_and_measure();
    half_ns = 100;
    test_foul();
    test_timeout();
    test_hit_with_tick();
    test_best_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
